inport_ctl: RTL

- Router input-port controller: the requesting side of the per-output arbitration and mux controller.
- Buffers incoming flits in a small FIFO and computes the XY output port from each head flit.
- Drives a req/port pair to the five output-port arbiters, holds the request for the whole packet, and pops one flit per granted cycle.
- One instance per router input port. The ready signal gives back-pressure to upstream.

---
 rtl/inport_ctl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/inport_ctl.sv
// Router input-port controller: flit FIFO, XY route of the head flit, and the
// req/port handshake toward the five output arbiters. One pop per granted cycle.
// Optional stall counter enabled with `define INPORT_STALLCNT_EN.
module inport_ctl #(
  parameter int PORTID   = 0,
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int DEPTH    = 4,
  parameter int DATAW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATAW+1:0]   flit_i,
  input  logic               flit_valid_i,
  output logic               ready_o,
  output logic               req_o,
  output logic [2:0]         port_o,
  input  logic [4:0]         grt_i,
  output logic [DATAW+1:0]   flit_o,
  output logic               flit_valid_o,
  output logic [15:0]        stall_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = DATAW + 2;
  localparam logic [3:0] RX = 4'(ROUTER_X);
  localparam logic [3:0] RY = 4'(ROUTER_Y);

  // Illegal configurations leave a conspicuously named scope in the hierarchy.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DATAW < 8 || PORTID < 0 || PORTID > 4)
  begin : g_bad_params_check
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, push, pop, pop_fwd, pop_drop;
  logic [FW-1:0] head;
  logic [1:0]    head_type;
  logic          head_is_hd, head_is_tl, grant;
  logic [2:0]    route, port_q;
  state_t        state;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign ready_o    = !full;
  assign head       = mem[rd_ptr];
  assign head_type  = head[FW-1:DATAW];
  assign head_is_hd = (head_type[1] == head_type[0]);  // 00 head, 11 head+tail
  assign head_is_tl = head_type[1];                    // 10 tail, 11 head+tail
  assign grant      = grt_i[port_q];
  assign port_o     = port_q;

  assign push     = flit_valid_i && !full;
  assign pop_fwd  = (state == ACTIVE) && grant && !empty;
  assign pop_drop = (state == IDLE) && !empty && !head_is_hd;
  assign pop      = pop_fwd || pop_drop;

  // XY routing: resolve X first, then Y, local port when both match.
  always_comb begin
    route = 3'd0;
    if (head[7:4] > RX)      route = 3'd2;
    else if (head[7:4] < RX) route = 3'd4;
    else if (head[3:0] > RY) route = 3'd3;
    else if (head[3:0] < RY) route = 3'd1;
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= flit_i;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Packet FSM: hold req for the whole packet, drop req one cycle after the tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_o        <= 1'b0;
      port_q       <= '0;
      flit_o       <= '0;
      flit_valid_o <= 1'b0;
    end else begin
      flit_valid_o <= pop_fwd;
      if (pop_fwd) flit_o <= head;
      case (state)
        IDLE: begin
          if (!empty && head_is_hd) begin
            port_q <= route;
            req_o  <= 1'b1;
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pop_fwd && head_is_tl) begin
            req_o <= 1'b0;
            state <= DRAIN;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INPORT_STALLCNT_EN
  // Count cycles spent requesting with data but no grant; clear on tail pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_o <= '0;
    else if (pop_fwd && head_is_tl)
      stall_cnt_o <= '0;
    else if (req_o && !grant && !empty && stall_cnt_o != 16'hFFFF)
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule
